int_muldiv_unit: RTL and testbench

- Parametrised iterative integer multiply/divide unit for the execute stage.
- Replaces the fixed 4-cycle delay counter used for T_INT/T_INTU ops with a true multi-cycle datapath: configurable width, bits-per-cycle and destination tag.
- Valid/ready handshake on both sides; flush input for pipeline redirects (interrupt, taken branch).
- Execute asserts its stall from accept until the result handshake.

---
 rtl/int_muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_int_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/int_muldiv_unit.sv
`default_nettype none
// ============================================================================
// int_muldiv_unit : iterative signed/unsigned multiply and divide, UNROLL bits per cycle
// Rev 1.0
// ============================================================================
module int_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             div0_o,
  output logic             busy_o
);

  localparam int ITERS = WIDTH / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int AW    = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] F_MUL   = 3'd0;
  localparam logic [2:0] F_MULH  = 3'd1;
  localparam logic [2:0] F_MULHU = 3'd2;
  localparam logic [2:0] F_DIV   = 3'd3;
  localparam logic [2:0] F_DIVU  = 3'd4;
  localparam logic [2:0] F_REM   = 3'd5;
  localparam logic [2:0] F_REMU  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       func_q, func_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             special_q, special_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             div0_q, div0_d;

  logic             is_mul, is_div, is_rem, signed_op;
  logic             a_sign, b_sign;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [AW-1:0]    step;
  logic [WIDTH:0]   upper, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign is_mul    = (func_q == F_MUL) || (func_q == F_MULH) || (func_q == F_MULHU);
  assign is_div    = (func_q == F_DIV) || (func_q == F_DIVU) || (func_q == F_REM) || (func_q == F_REMU);
  assign is_rem    = (func_q == F_REM) || (func_q == F_REMU);
  assign signed_op = (func_q == F_MULH) || (func_q == F_DIV) || (func_q == F_REM);

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    result_d  = result_q;
    div0_d    = div0_q;
    a_sign    = signed_op && a_q[WIDTH-1];
    b_sign    = signed_op && b_q[WIDTH-1];
    a_abs     = a_sign ? -a_q : a_q;
    b_abs     = b_sign ? -b_q : b_q;
    step      = acc_q;
    upper     = '0;
    trial     = '0;
    prod      = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !flush_i) begin
          state_d   = S_PREP;
          func_d    = func_i;
          a_d       = a_i;
          b_d       = b_i;
          tag_d     = tag_i;
          div0_d    = 1'b0;
          special_d = 1'b0;
        end
      end
      S_PREP: begin
        a_d       = a_abs;
        b_d       = b_abs;
        neg_res_d = a_sign ^ b_sign;
        neg_rem_d = a_sign;
        cnt_d     = CW'(ITERS);
        acc_d     = is_mul ? {{(WIDTH+1){1'b0}}, b_abs} : {{(WIDTH+1){1'b0}}, a_abs};
        state_d   = S_ITER;
        // Special cases still pass through FIX so their latency is a fixed two cycles.
        if (is_div && (b_q == '0)) begin
          special_d = 1'b1;
          div0_d    = 1'b1;
          result_d  = is_rem ? a_q : '1;
          state_d   = S_FIX;
        end else if (is_div && signed_op && (a_q == MIN_VAL) && (b_q == '1)) begin
          special_d = 1'b1;
          result_d  = is_rem ? '0 : MIN_VAL;
          state_d   = S_FIX;
        end else if (!is_mul && !is_div) begin
          special_d = 1'b1;
          result_d  = '0;
          state_d   = S_FIX;
        end
      end
      S_ITER: begin
        for (int i = 0; i < UNROLL; i++) begin
          if (is_mul) begin
            upper = {1'b0, step[2*WIDTH-1:WIDTH]} + (step[0] ? {1'b0, a_q} : '0);
            step  = {1'b0, upper, step[WIDTH-1:1]};
          end else begin
            step  = {step[AW-2:0], 1'b0};
            trial = step[2*WIDTH:WIDTH] - {1'b0, b_q};
            if (step[2*WIDTH:WIDTH] >= {1'b0, b_q}) begin
              step[2*WIDTH:WIDTH] = trial;
              step[0]             = 1'b1;
            end
          end
        end
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!special_q) begin
          case (func_q)
            F_MUL:            result_d = prod[WIDTH-1:0];
            F_MULH, F_MULHU:  result_d = prod[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:    result_d = quo;
            F_REM, F_REMU:    result_d = rem;
            default:          result_d = '0;
          endcase
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
      result_q  <= result_d;
      div0_q    <= div0_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE) && !flush_i;
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;
  assign tag_o       = tag_q;
  assign div0_o      = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_int_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_int_muldiv_unit : directed vectors for int_muldiv_unit (UNROLL=1 and UNROLL=4)
// Rev 1.0
// ============================================================================
module tb_int_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid4 = 1'b0;
  logic        in_ready, in_ready4;
  logic [2:0]  func = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  tag = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b0, out_ready4 = 1'b0;
  logic [31:0] result, result4;
  logic [3:0]  tag_o, tag_o4;
  logic        div0, div04;
  logic        busy, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_muldiv_unit #(.WIDTH(32), .UNROLL(1), .TAG_W(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .func_i(func), .a_i(a), .b_i(b), .tag_i(tag), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .tag_o(tag_o), .div0_o(div0), .busy_o(busy)
  );

  int_muldiv_unit #(.WIDTH(32), .UNROLL(4), .TAG_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .func_i(func), .a_i(a), .b_i(b), .tag_i(tag), .flush_i(flush),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4), .result_o(result4),
    .tag_o(tag_o4), .div0_o(div04), .busy_o(busy4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] t);
    @(negedge clk);
    func = f; a = av; b = bv; tag = t; in_valid = 1'b1;
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    func = 3'($urandom); a = $urandom; b = $urandom; tag = 4'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_handshake", {62'd0, busy, out_valid}, 64'd0);
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [3:0] t, input logic [31:0] exp,
                       input logic exp_div0, input int exp_lat);
    int cyc;
    issue(f, av, bv, t);
    wait_valid(cyc);
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({name, "_result"}, {32'd0, result}, {32'd0, exp});
    check({name, "_tag"}, {60'd0, tag_o}, {60'd0, t});
    check({name, "_div0"}, {63'd0, div0}, {63'd0, exp_div0});
    handshake();
  endtask

  initial begin
    int cyc;
    int rose;

    #12;
    check("reset_outputs", {57'd0, out_valid, busy, div0, tag_o}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("ready_after_reset", {62'd0, in_ready, in_ready4}, 64'd3);

    do_op("mulhu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1, 32'hFFFF_FFFE, 1'b0, 34);
    do_op("mul_max",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 32'h0000_0001, 1'b0, 34);
    do_op("mulh_neg",  3'd1, 32'hFFFF_FFFF, 32'd2,         4'h3, 32'hFFFF_FFFF, 1'b0, 34);
    do_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 4'h4, 32'h4000_0000, 1'b0, 34);
    do_op("div_neg",   3'd3, 32'hFFFF_FFF9, 32'd2,         4'h5, 32'hFFFF_FFFD, 1'b0, 34);
    do_op("rem_neg",   3'd5, 32'hFFFF_FFF9, 32'd2,         4'h6, 32'hFFFF_FFFF, 1'b0, 34);
    do_op("divu",      3'd4, 32'd100,       32'd7,         4'h7, 32'd14,        1'b0, 34);
    do_op("remu",      3'd6, 32'd100,       32'd7,         4'h8, 32'd2,         1'b0, 34);
    do_op("divu_max1", 3'd4, 32'hFFFF_FFFF, 32'd1,         4'h9, 32'hFFFF_FFFF, 1'b0, 34);
    do_op("divu_by0",  3'd4, 32'h0000_1234, 32'd0,         4'hB, 32'hFFFF_FFFF, 1'b1, 2);
    do_op("rem_by0",   3'd5, 32'h0000_1234, 32'd0,         4'hC, 32'h0000_1234, 1'b1, 2);
    do_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'hD, 32'h8000_0000, 1'b0, 2);
    do_op("func7",     3'd7, 32'd55,        32'd66,        4'hE, 32'd0,         1'b0, 2);

    // Flush in the tenth ITER cycle, then watch that no result appears.
    issue(3'd4, 32'd100, 32'd7, 4'h5);
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {62'd0, busy, out_valid}, 64'd0);
    do_op("divu_after_flush", 3'd4, 32'd9, 32'd3, 4'h6, 32'd3, 1'b0, 34);

    // Flush while idle blocks a request.
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; func = 3'd0;
    #1 check("flush_idle_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("flush_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    rose = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) rose = 1;
    end
    check("no_spurious_valid", 64'(rose), 64'd0);

    // Asynchronous reset in the middle of an operation.
    issue(3'd0, 32'd77, 32'd5, 4'hF);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_ctl", {57'd0, out_valid, busy, div0, tag_o}, 64'd0);
    check("async_reset_result", {32'd0, result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("ready_after_rerelease", {63'd0, in_ready}, 64'd1);

    // Backpressure: hold the result for five cycles.
    issue(3'd4, 32'd100, 32'd7, 4'hA);
    wait_valid(cyc);
    rose = 0;
    repeat (5) begin
      if (!out_valid || result !== 32'd14 || tag_o !== 4'hA) rose++;
      @(posedge clk); #1;
    end
    check("backpressure_hold", 64'(rose), 64'd0);
    check("backpressure_result", {32'd0, result}, 64'd14);
    handshake();

    // UNROLL=4 instance.
    @(negedge clk);
    func = 3'd0; a = 32'd12345; b = 32'd678; tag = 4'h3; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a = $urandom; b = $urandom; tag = 4'h0;
    cyc = 0;
    while (!out_valid4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("u4_latency", 64'(cyc), 64'd10);
    check("u4_result", {32'd0, result4}, 64'd8369910);
    check("u4_tag_div0", {59'd0, div04, tag_o4}, 64'h3);
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1; out_ready4 = 1'b0;
    check("u4_idle", {62'd0, busy4, out_valid4}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
